ps2_key_tracker: RTL and testbench

- Sits directly downstream of the PS/2 controller's received_data / received_data_en byte stream.
- Parses PS/2 set-2 make, break (F0) and extended (E0) sequences.
- Maintains held state for the four Pong paddle keys, a pause toggle, and per-player move commands for the game logic.
- Recovers from truncated prefix sequences with a timeout.

---
 rtl/ps2_key_tracker.sv | 170 +++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 set-2 scancode parser tracking Pong paddle keys and pause
// Decodes make/break/extended sequences and abandons stale prefixes after PREFIX_TIMEOUT cycles.
module ps2_key_tracker #(
    parameter int PREFIX_TIMEOUT = 50000,
    parameter int TW             = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       p1_up_held,
    output logic       p1_down_held,
    output logic       p2_up_held,
    output logic       p2_down_held,
    output logic [1:0] p1_move,
    output logic [1:0] p2_move,
    output logic       pause,
    output logic       key_event,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]    CODE_EXT   = 8'hE0;
    localparam logic [7:0]    CODE_BRK   = 8'hF0;
    localparam logic [7:0]    CODE_W     = 8'h1D;
    localparam logic [7:0]    CODE_S     = 8'h1B;
    localparam logic [7:0]    CODE_SPACE = 8'h29;
    localparam logic [7:0]    CODE_UP    = 8'h75;
    localparam logic [7:0]    CODE_DOWN  = 8'h72;
    localparam logic [TW-1:0] CNT_LAST   = TW'(PREFIX_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic apply, apply_ext, apply_brk;

    logic       p1_up_q, p1_up_d;
    logic       p1_down_q, p1_down_d;
    logic       p2_up_q, p2_up_d;
    logic       p2_down_q, p2_down_d;
    logic [1:0] p1_move_q, p1_move_d;
    logic [1:0] p2_move_q, p2_move_d;
    logic       pause_q, pause_d;
    logic       space_held_q, space_held_d;
    logic       key_event_q, key_event_d;
    logic       timeout_err_q, timeout_err_d;

    function automatic logic [1:0] move_of(input logic up, input logic down);
        if (up && !down) begin
            return 2'b01;
        end else if (down && !up) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A strobe always wins over the timeout, so a byte landing on the last cycle is never lost.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        apply         = 1'b0;
        apply_ext     = (state_q == EXT) || (state_q == EXT_BRK);
        apply_brk     = (state_q == BRK) || (state_q == EXT_BRK);
        if (received_data_en) begin
            cnt_d = '0;
            if (received_data == CODE_EXT) begin
                state_d = EXT;
            end else if (received_data == CODE_BRK) begin
                state_d = apply_ext ? EXT_BRK : BRK;
            end else begin
                state_d = IDLE;
                apply   = 1'b1;
            end
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d       = IDLE;
                cnt_d         = '0;
                timeout_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_comb begin
        p1_up_d      = p1_up_q;
        p1_down_d    = p1_down_q;
        p2_up_d      = p2_up_q;
        p2_down_d    = p2_down_q;
        pause_d      = pause_q;
        space_held_d = space_held_q;
        key_event_d  = 1'b0;
        if (apply) begin
            key_event_d = 1'b1;
            case ({apply_ext, received_data})
                {1'b0, CODE_W}:    p1_up_d   = !apply_brk;
                {1'b0, CODE_S}:    p1_down_d = !apply_brk;
                {1'b1, CODE_UP}:   p2_up_d   = !apply_brk;
                {1'b1, CODE_DOWN}: p2_down_d = !apply_brk;
                {1'b0, CODE_SPACE}: begin
                    if (apply_brk) begin
                        space_held_d = 1'b0;
                    end else if (!space_held_q) begin
                        pause_d      = !pause_q;
                        space_held_d = 1'b1;
                    end
                end
                default: key_event_d = 1'b0;
            endcase
        end
        p1_move_d = move_of(p1_up_d, p1_down_d);
        p2_move_d = move_of(p2_up_d, p2_down_d);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            p1_up_q       <= 1'b0;
            p1_down_q     <= 1'b0;
            p2_up_q       <= 1'b0;
            p2_down_q     <= 1'b0;
            p1_move_q     <= 2'b00;
            p2_move_q     <= 2'b00;
            pause_q       <= 1'b0;
            space_held_q  <= 1'b0;
            key_event_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            p1_up_q       <= p1_up_d;
            p1_down_q     <= p1_down_d;
            p2_up_q       <= p2_up_d;
            p2_down_q     <= p2_down_d;
            p1_move_q     <= p1_move_d;
            p2_move_q     <= p2_move_d;
            pause_q       <= pause_d;
            space_held_q  <= space_held_d;
            key_event_q   <= key_event_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign p1_up_held   = p1_up_q;
    assign p1_down_held = p1_down_q;
    assign p2_up_held   = p2_up_q;
    assign p2_down_held = p2_down_q;
    assign p1_move      = p1_move_q;
    assign p2_move      = p2_move_q;
    assign pause        = pause_q;
    assign key_event    = key_event_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed and randomized check of ps2_key_tracker against a sequence-level model
module tb_ps2_key_tracker;

    localparam int PT = 8;

    logic       clk;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       p1_up_held, p1_down_held, p2_up_held, p2_down_held;
    logic [1:0] p1_move, p2_move;
    logic       pause, key_event, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending prefix flags, idle cycles since last prefix byte, and key state.
    bit m_seq, m_ext, m_brk;
    int m_idle;
    bit m_p1u, m_p1d, m_p2u, m_p2d, m_pause, m_space, m_ke, m_to;

    ps2_key_tracker #(.PREFIX_TIMEOUT(PT), .TW(4)) dut (
        .CLOCK_50         (clk),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .p1_up_held       (p1_up_held),
        .p1_down_held     (p1_down_held),
        .p2_up_held       (p2_up_held),
        .p2_down_held     (p2_down_held),
        .p1_move          (p1_move),
        .p2_move          (p2_move),
        .pause            (pause),
        .key_event        (key_event),
        .timeout_err      (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_move(input bit up, input bit down);
        if (up == down) return 2'b00;
        return up ? 2'b01 : 2'b10;
    endfunction

    task automatic model_clear();
        m_seq = 0; m_ext = 0; m_brk = 0; m_idle = 0;
        m_p1u = 0; m_p1d = 0; m_p2u = 0; m_p2d = 0;
        m_pause = 0; m_space = 0; m_ke = 0; m_to = 0;
    endtask

    task automatic model_apply(input bit ext, input bit brk, input logic [7:0] b);
        m_ke = 1;
        if (!ext && b == 8'h1D)      m_p1u = !brk;
        else if (!ext && b == 8'h1B) m_p1d = !brk;
        else if (ext && b == 8'h75)  m_p2u = !brk;
        else if (ext && b == 8'h72)  m_p2d = !brk;
        else if (!ext && b == 8'h29) begin
            if (brk) m_space = 0;
            else if (!m_space) begin
                m_pause = !m_pause;
                m_space = 1;
            end
        end else m_ke = 0;
    endtask

    task automatic check_outs(input string where);
        check({where, ".held"}, {p1_up_held, p1_down_held, p2_up_held, p2_down_held},
              {m_p1u, m_p1d, m_p2u, m_p2d});
        check({where, ".p1_move"}, p1_move, exp_move(m_p1u, m_p1d));
        check({where, ".p2_move"}, p2_move, exp_move(m_p2u, m_p2d));
        check({where, ".pause"}, pause, m_pause);
        check({where, ".key_event"}, key_event, m_ke);
        check({where, ".timeout_err"}, timeout_err, m_to);
    endtask

    task automatic step(input bit en, input logic [7:0] data);
        @(negedge clk);
        received_data_en = en;
        received_data    = data;
        m_ke = 0;
        m_to = 0;
        if (en) begin
            m_idle = 0;
            if (data == 8'hE0) begin
                m_seq = 1; m_ext = 1; m_brk = 0;
            end else if (data == 8'hF0) begin
                m_seq = 1; m_brk = 1;
            end else begin
                model_apply(m_ext, m_brk, data);
                m_seq = 0; m_ext = 0; m_brk = 0;
            end
        end else if (m_seq) begin
            m_idle++;
            if (m_idle == PT) begin
                m_to = 1;
                m_seq = 0; m_ext = 0; m_brk = 0; m_idle = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outs("cyc");
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1, b);
        repeat (gap) step(0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        received_data_en = 0;
        reset = 1;
        #1;
        model_clear();
        check_outs("rst_async");
        @(posedge clk);
        #1;
        check_outs("rst_hold");
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        reset = 1;
        received_data = 8'h00;
        received_data_en = 0;
        model_clear();
        #1;
        check_outs("rst0");
        do_reset();

        // W make / break
        send(8'h1D, 10); send(8'hF0, 0); send(8'h1D, 10);
        // arrows and keypad 8
        send(8'hE0, 0); send(8'h75, 3); send(8'hE0, 0); send(8'h72, 3);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 3);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h72, 2); send(8'h75, 3);
        // pause with typematic repeats
        send(8'h29, 2); send(8'h29, 2); send(8'h29, 2); send(8'hF0, 1); send(8'h29, 2); send(8'h29, 2);
        // prefix timeout then make, and strobe exactly on timeout cycle
        send(8'hF0, PT); send(8'h1B, 3);
        send(8'h1D, 2); send(8'hF0, PT - 1); send(8'h1D, 3);
        // reset mid-sequence
        send(8'h1D, 1); send(8'hE0, 0); send(8'h75, 1); send(8'hE0, 0);
        do_reset();
        send(8'h72, 3);

        for (int i = 0; i < 500; i++) begin
            logic [7:0] b;
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2, 9:    b = 8'hF0;
                3:       b = 8'h1D;
                4:       b = 8'h1B;
                5:       b = 8'h29;
                6:       b = 8'h75;
                7:       b = 8'h72;
                default: b = 8'($urandom);
            endcase
            send(b, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : 0);
            if ($urandom_range(0, 79) == 0) do_reset();
        end
        step(0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
